// File: rtl/repeat_sig_gen_param_if.sv
// Coordinate-in / repeat-signal-out stream bundle for repeat_sig_gen_param.
// The slave modport is the generator's view; master is the upstream/downstream environment.
interface repeat_sig_gen_param_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH:0] base_data_in;
  logic                base_data_in_valid;
  logic                base_data_in_ready;
  logic [DATA_WIDTH:0] repsig_data_out;
  logic                repsig_data_out_valid;
  logic                repsig_data_out_ready;

  modport master (
    output base_data_in,
    output base_data_in_valid,
    input  base_data_in_ready,
    input  repsig_data_out,
    input  repsig_data_out_valid,
    output repsig_data_out_ready
  );

  modport slave (
    input  base_data_in,
    input  base_data_in_valid,
    output base_data_in_ready,
    output repsig_data_out,
    output repsig_data_out_valid,
    input  repsig_data_out_ready
  );
endinterface

// File: rtl/repeat_sig_gen_param.sv
// Sparse repeat-signal generator: one (or rep_count) R tokens per coordinate, rebased STOP
// forwarding, DONE forwarding with a tile_done pulse, and skid FIFOs on both sides.
module repeat_sig_gen_param #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_DEPTH   = 2,
  parameter int OUT_DEPTH  = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 flush,
  input  logic                 tile_en,
  input  logic                 mode,
  input  logic [CNT_WIDTH-1:0] rep_count,
  input  logic [7:0]           stop_lvl,
  output logic                 tile_done,
  repeat_sig_gen_param_if.slave bus
);
  localparam int W   = DATA_WIDTH + 1;
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [W-1:0] R_WORD = {1'b0, DATA_WIDTH'(1)};

  typedef enum logic [1:0] {S_IDLE, S_REP, S_CTRL, S_DONE} state_t;

  // ---------------- input FIFO ----------------
  logic [W-1:0] in_mem [IN_DEPTH];
  logic [IAW:0] in_wr_reg, in_rd_reg;
  logic         in_full, in_empty, in_push, in_pop;
  logic         alive_reg;

  assign in_empty = (in_wr_reg == in_rd_reg);
  assign in_full  = (in_wr_reg[IAW] != in_rd_reg[IAW]) &&
                    (in_wr_reg[IAW-1:0] == in_rd_reg[IAW-1:0]);
  // alive_reg keeps ready low while in reset and for the cycle after a flush
  assign bus.base_data_in_ready = alive_reg & tile_en & ~in_full;
  assign in_push = bus.base_data_in_valid & bus.base_data_in_ready & clk_en;

  always_ff @(posedge clk) begin
    if (in_push)
      in_mem[in_wr_reg[IAW-1:0]] <= bus.base_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wr_reg <= '0;
      in_rd_reg <= '0;
    end else if (clk_en) begin
      if (flush) begin
        in_wr_reg <= '0;
        in_rd_reg <= '0;
      end else begin
        if (in_push) in_wr_reg <= in_wr_reg + 1'b1;
        if (in_pop)  in_rd_reg <= in_rd_reg + 1'b1;
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic [W-1:0] out_mem [OUT_DEPTH];
  logic [OAW:0] out_wr_reg, out_rd_reg;
  logic         out_full, out_empty, out_push, out_pop;
  logic [W-1:0] out_word;

  assign out_empty = (out_wr_reg == out_rd_reg);
  assign out_full  = (out_wr_reg[OAW] != out_rd_reg[OAW]) &&
                     (out_wr_reg[OAW-1:0] == out_rd_reg[OAW-1:0]);
  assign bus.repsig_data_out_valid = tile_en & ~out_empty;
  assign bus.repsig_data_out = bus.repsig_data_out_valid ? out_mem[out_rd_reg[OAW-1:0]] : '0;
  assign out_pop = bus.repsig_data_out_valid & bus.repsig_data_out_ready & clk_en;

  always_ff @(posedge clk) begin
    if (out_push && clk_en)
      out_mem[out_wr_reg[OAW-1:0]] <= out_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wr_reg <= '0;
      out_rd_reg <= '0;
    end else if (clk_en) begin
      if (flush) begin
        out_wr_reg <= '0;
        out_rd_reg <= '0;
      end else begin
        if (out_push) out_wr_reg <= out_wr_reg + 1'b1;
        if (out_pop)  out_rd_reg <= out_rd_reg + 1'b1;
      end
    end
  end

  // ---------------- control FSM ----------------
  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 tile_done_reg, done_set;
  logic [W-1:0]         head;
  logic                 head_ctrl, head_done;
  logic [8:0]           lvl_sum;
  logic [7:0]           stop_sat;

  assign head      = in_mem[in_rd_reg[IAW-1:0]];
  assign head_ctrl = head[DATA_WIDTH];
  assign head_done = head_ctrl & head[8];
  assign lvl_sum   = {1'b0, head[7:0]} + {1'b0, stop_lvl};
  assign stop_sat  = lvl_sum[8] ? 8'hFF : lvl_sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= S_IDLE;
    else if (clk_en)
      state_reg <= flush ? S_IDLE : state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!tile_en) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (!in_empty) begin
            if (head_done)                        state_next = S_DONE;
            else if (head_ctrl)                   state_next = S_CTRL;
            else if (!mode || (rep_count != '0))  state_next = S_REP;
          end
        end
        S_REP:   if (!out_full && (cnt_reg == CNT_WIDTH'(1))) state_next = S_IDLE;
        S_CTRL:  if (!out_full) state_next = S_IDLE;
        S_DONE:  if (!out_full) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_pop   = 1'b0;
    out_push = 1'b0;
    out_word = '0;
    cnt_next = cnt_reg;
    done_set = 1'b0;
    if (!tile_en) begin
      cnt_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // a zero count in counted mode drops the coordinate right here
          if (!in_empty && !head_ctrl) begin
            in_pop   = 1'b1;
            cnt_next = mode ? rep_count : CNT_WIDTH'(1);
          end
        end
        S_REP: begin
          if (!out_full) begin
            out_push = 1'b1;
            out_word = R_WORD;
            cnt_next = cnt_reg - 1'b1;
          end
        end
        S_CTRL: begin
          if (!out_full) begin
            in_pop   = 1'b1;
            out_push = 1'b1;
            out_word = {1'b1, {(DATA_WIDTH-8){1'b0}}, stop_sat};
          end
        end
        S_DONE: begin
          if (!out_full) begin
            in_pop   = 1'b1;
            out_push = 1'b1;
            out_word = head;
            done_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      tile_done_reg <= 1'b0;
      alive_reg     <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        cnt_reg       <= '0;
        tile_done_reg <= 1'b0;
        alive_reg     <= 1'b0;
      end else begin
        cnt_reg       <= cnt_next;
        tile_done_reg <= done_set;
        alive_reg     <= 1'b1;
      end
    end
  end

  assign tile_done = tile_done_reg;
endmodule

// File: tb/tb_repeat_sig_gen_param.sv
// Directed and randomized checks of repeat_sig_gen_param against a token-level model.
module tb_repeat_sig_gen_param;
  localparam int DW = 16;
  localparam logic [DW:0] R_TOK = 17'h00001;
  localparam logic [DW:0] D_TOK = 17'h10100;

  logic       clk = 1'b0;
  logic       rst_n, clk_en, flush, tile_en, mode, tile_done;
  logic [7:0] rep_count, stop_lvl;

  repeat_sig_gen_param_if #(.DATA_WIDTH(DW)) bus ();

  repeat_sig_gen_param #(.DATA_WIDTH(DW), .IN_DEPTH(2), .OUT_DEPTH(2), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .mode(mode), .rep_count(rep_count), .stop_lvl(stop_lvl), .tile_done(tile_done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int r_seen   = 0;
  logic [DW:0] in_q[$];
  logic [DW:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [DW:0] stop_tok(input int lvl);
    logic [7:0] l;
    l = lvl[7:0];
    return {1'b1, 8'h00, l};
  endfunction

  // Token-level reference: what the output stream must contain for in_q
  task automatic build_expected(input bit m, input int rc, input int sl);
    int s;
    exp_q.delete();
    foreach (in_q[i]) begin
      if (!in_q[i][DW]) begin
        repeat (m ? rc : 1) exp_q.push_back(R_TOK);
      end else if (in_q[i][8]) begin
        exp_q.push_back(in_q[i]);
      end else begin
        s = int'(in_q[i][7:0]) + sl;
        if (s > 255) s = 255;
        exp_q.push_back(stop_tok(s));
      end
    end
  endtask

  task automatic run_stream(input string name, input int in_pct, input int out_pct,
                            input int max_cyc);
    int idx = 0, cyc = 0, dones = 0, exp_dones = 0, n_out = 0;
    bit held_valid = 0;
    logic [DW:0] held = '0;
    logic [DW:0] e;
    foreach (in_q[i]) if (in_q[i][DW] && in_q[i][8]) exp_dones++;
    while ((idx < in_q.size() || exp_q.size() > 0) && cyc < max_cyc) begin
      @(negedge clk);
      if (idx < in_q.size()) begin
        bus.base_data_in       = in_q[idx];
        bus.base_data_in_valid = ($urandom_range(99) < in_pct);
      end else begin
        bus.base_data_in       = '0;
        bus.base_data_in_valid = 1'b0;
      end
      bus.repsig_data_out_ready = ($urandom_range(99) < out_pct);
      #1;
      if (tile_done) dones++;
      if (held_valid) begin
        check({name, "_stall_valid"}, 32'(bus.repsig_data_out_valid), 32'd1);
        check({name, "_stall_data"}, 32'(bus.repsig_data_out), 32'(held));
      end
      held_valid = 0;
      if (bus.repsig_data_out_valid) begin
        if (bus.repsig_data_out_ready) begin
          if (exp_q.size() == 0) begin
            check({name, "_extra_out"}, 32'(bus.repsig_data_out), 32'h0BAD);
          end else begin
            e = exp_q.pop_front();
            check({name, "_out_word"}, 32'(bus.repsig_data_out), 32'(e));
          end
          if (bus.repsig_data_out == R_TOK) r_seen++;
          n_out++;
        end else begin
          held_valid = 1;
          held = bus.repsig_data_out;
        end
      end
      if (bus.base_data_in_valid && bus.base_data_in_ready) idx++;
      cyc++;
    end
    check({name, "_all_inputs_taken"}, 32'(idx), 32'(in_q.size()));
    check({name, "_outputs_drained"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    bus.base_data_in_valid    = 1'b0;
    bus.repsig_data_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (tile_done) dones++;
    end
    check({name, "_tail_valid"}, 32'(bus.repsig_data_out_valid), 32'd0);
    check({name, "_tile_done_count"}, 32'(dones), 32'(exp_dones));
    $display("stream %s: %0d inputs, %0d outputs, %0d cycles", name, idx, n_out, cyc);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
    mode = 1'b0; rep_count = '0; stop_lvl = '0;
    bus.base_data_in = '0; bus.base_data_in_valid = 1'b0; bus.repsig_data_out_ready = 1'b0;

    // reset state
    #2;
    check("rst_out_valid", 32'(bus.repsig_data_out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.base_data_in_ready), 32'd0);
    check("rst_out_data", 32'(bus.repsig_data_out), 32'd0);
    check("rst_tile_done", 32'(tile_done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    #1 check("ready_after_reset", 32'(bus.base_data_in_ready), 32'd1);

    // first-output latency: accept edge, then two more edges until valid
    @(negedge clk);
    bus.base_data_in = 17'h00005; bus.base_data_in_valid = 1'b1;
    #1 check("lat_accept_ready", 32'(bus.base_data_in_ready), 32'd1);
    @(negedge clk) bus.base_data_in_valid = 1'b0;
    #1 check("lat_edge1_valid", 32'(bus.repsig_data_out_valid), 32'd0);
    @(negedge clk);
    #1 check("lat_edge2_valid", 32'(bus.repsig_data_out_valid), 32'd0);
    @(negedge clk);
    #1 check("lat_edge3_valid", 32'(bus.repsig_data_out_valid), 32'd1);
    check("lat_word", 32'(bus.repsig_data_out), 32'(R_TOK));
    do_flush();

    // 1: classic mode
    mode = 1'b0; stop_lvl = 8'd0;
    in_q = '{17'h00005, 17'h00007, stop_tok(0), D_TOK};
    build_expected(0, 1, 0);
    run_stream("classic", 100, 100, 200);

    // 2: counted mode with rebased stops
    mode = 1'b1; rep_count = 8'd3; stop_lvl = 8'd1;
    in_q = '{17'h00004, stop_tok(0), stop_tok(1), D_TOK};
    build_expected(1, 3, 1);
    run_stream("counted3", 100, 100, 200);

    // 3: zero count drops coordinates
    mode = 1'b1; rep_count = 8'd0; stop_lvl = 8'd0;
    in_q = '{17'h00009, 17'h00009, stop_tok(0), D_TOK};
    build_expected(1, 0, 0);
    run_stream("count0", 100, 100, 200);

    // 4: stop level saturation
    mode = 1'b0; stop_lvl = 8'd250;
    in_q = '{stop_tok(10), D_TOK};
    build_expected(0, 1, 250);
    run_stream("saturate", 100, 100, 200);

    // 5: 200 random coordinates with stops, random valid and 50% backpressure
    mode = 1'b1; rep_count = 8'd2; stop_lvl = 8'($urandom_range(255));
    in_q.delete();
    for (int i = 0; i < 200; i++) begin
      in_q.push_back({1'b0, 16'($urandom_range(16'hFFFF))});
      if ($urandom_range(9) == 0) in_q.push_back(stop_tok($urandom_range(255)));
    end
    in_q.push_back(D_TOK);
    build_expected(1, 2, int'(stop_lvl));
    r_seen = 0;
    run_stream("random_bp", 75, 50, 5000);
    check("random_r_count", 32'(r_seen), 32'd400);

    // 6a: async reset mid-burst clears outputs at once and leaves nothing behind
    mode = 1'b1; rep_count = 8'd3; bus.repsig_data_out_ready = 1'b0;
    @(negedge clk);
    bus.base_data_in = 17'h00004; bus.base_data_in_valid = 1'b1;
    @(negedge clk) bus.base_data_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check("midrep_valid", 32'(bus.repsig_data_out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.repsig_data_out_valid), 32'd0);
    check("async_rst_ready", 32'(bus.base_data_in_ready), 32'd0);
    check("async_rst_data", 32'(bus.repsig_data_out), 32'd0);
    check("async_rst_done", 32'(tile_done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    bus.repsig_data_out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1 check("post_rst_no_partial", 32'(bus.repsig_data_out_valid), 32'd0);

    // 6b: flush mid-burst, then a fresh tile
    mode = 1'b0; bus.repsig_data_out_ready = 1'b0;
    @(negedge clk);
    bus.base_data_in = 17'h00005; bus.base_data_in_valid = 1'b1;
    @(negedge clk) bus.base_data_in = 17'h00006;
    @(negedge clk) bus.base_data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("preflush_valid", 32'(bus.repsig_data_out_valid), 32'd1);
    do_flush();
    #1;
    check("flush_valid", 32'(bus.repsig_data_out_valid), 32'd0);
    check("flush_ready", 32'(bus.base_data_in_ready), 32'd0);
    in_q = '{17'h00003, D_TOK};
    build_expected(0, 1, 0);
    run_stream("after_flush", 100, 100, 200);

    // clk_en low freezes both FIFOs even with valid and ready asserted
    mode = 1'b0; bus.repsig_data_out_ready = 1'b0;
    @(negedge clk);
    bus.base_data_in = 17'h00007; bus.base_data_in_valid = 1'b1;
    @(negedge clk) bus.base_data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    clk_en = 1'b0;
    bus.repsig_data_out_ready = 1'b1;
    bus.base_data_in = 17'h00009; bus.base_data_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("clken_hold_valid", 32'(bus.repsig_data_out_valid), 32'd1);
      check("clken_hold_data", 32'(bus.repsig_data_out), 32'(R_TOK));
    end
    bus.base_data_in_valid = 1'b0;
    bus.repsig_data_out_ready = 1'b0;
    @(negedge clk) clk_en = 1'b1;
    in_q = '{D_TOK};
    build_expected(0, 1, 0);
    exp_q.push_front(R_TOK);
    run_stream("clken_resume", 100, 100, 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
